// File: rtl/riscv_fetch_pkg.sv
// Shared fetch types: FSM states, buffer entry layout, and default address constants.
// No logic here, so it has no latency or backpressure of its own.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT,
        TRAP
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int          INST_BYTES   = 4;
    localparam logic [63:0] DEF_RESET_PC = 64'h0;
    localparam logic [63:0] DEF_PROG_END = 64'd148;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: {pc, inst} buffer with 1-cycle write-to-read latency and up to 4 entries.
// Backpressure: the owner gates push on full (unless it also pops); flush beats push/pop.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_dat,
    output fetch_entry_t rd_dat,
    output logic [2:0]   count
);

    localparam logic [1:0] LAST = 2'(DEPTH - 1);

    // Storage is sized for the largest legal DEPTH so 2-bit pointers index it exactly.
    fetch_entry_t mem [4];
    logic [1:0]   rd_ptr;
    logic [1:0]   wr_ptr;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer feeding a fetch_fifo; first word valid 1 cycle after reset, redirect target valid 2 cycles after.
// Stalls on a full buffer with no pop; FETCH_PERF_CNT_EN adds Fetch_Count/Flush_Count.
module instruction_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEF_RESET_PC,
    parameter logic [63:0] PROG_END = DEF_PROG_END,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        Branch_Taken,
    input  logic [63:0] Branch_Target,
    output logic        Fetch_Valid,
    input  logic        Fetch_Ready,
    output logic [31:0] Fetch_Instruction,
    output logic [63:0] Fetch_PC,
    output logic        Halted,
    output logic        Trap
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_Count,
    output logic [31:0] Flush_Count
`endif
);

    localparam logic [2:0] DEPTH_CNT = 3'(DEPTH);

    fetch_state_t state;
    logic [63:0]  pc;
    logic [63:0]  pc_next4;
    logic [2:0]   count;
    logic [2:0]   count_after;
    fetch_entry_t head;
    fetch_entry_t wr_entry;
    logic         redirect;
    logic         misaligned;
    logic         pop;
    logic         push;

    // A trapped core ignores redirects, so only non-TRAP requests flush.
    assign redirect    = Branch_Taken && (state != TRAP);
    assign misaligned  = (Branch_Target[1:0] != 2'b00);
    assign Fetch_Valid = (count != 3'd0);
    assign pop         = Fetch_Valid && Fetch_Ready && !redirect;
    assign push        = (state == RUN) && !redirect && ((count < DEPTH_CNT) || pop);
    assign pc_next4    = pc + 64'(INST_BYTES);
    assign count_after = count + {2'b00, push} - {2'b00, pop};
    assign wr_entry    = '{pc: pc, inst: Instruction};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .flush  (redirect),
        .wr_dat (wr_entry),
        .rd_dat (head),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc    <= RESET_PC;
            state <= (RESET_PC >= PROG_END) ? HALT : RUN;
            Trap  <= 1'b0;
        end else if (state == TRAP) begin
            state <= TRAP;
        end else if (redirect) begin
            if (misaligned) begin
                state <= TRAP;
                Trap  <= 1'b1;
            end else begin
                pc    <= Branch_Target;
                state <= (Branch_Target >= PROG_END) ? HALT : RUN;
            end
        end else begin
            if (push) begin
                pc <= pc_next4;
                if (pc_next4 >= PROG_END) state <= (count_after != 3'd0) ? DRAIN : HALT;
            end
            if ((state == DRAIN) && pop && (count == 3'd1)) state <= HALT;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            Fetch_Count <= 32'd0;
            Flush_Count <= 32'd0;
        end else begin
            if (push)     Fetch_Count <= Fetch_Count + 32'd1;
            if (redirect) Flush_Count <= Flush_Count + {29'd0, count};
        end
    end
`endif

    assign Inst_Address      = pc;
    assign Fetch_Instruction = Fetch_Valid ? head.inst : 32'd0;
    assign Fetch_PC          = Fetch_Valid ? head.pc : 64'd0;
    assign Halted            = (pc >= PROG_END) && (count == 3'd0);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, end-of-program sequence, then random traffic vs a queue model.
module tb_instruction_fetch;

    localparam logic [63:0] PROG_END = 64'd148;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        Branch_Taken;
    logic [63:0] Branch_Target;
    logic        Fetch_Valid;
    logic        Fetch_Ready;
    logic [31:0] Fetch_Instruction;
    logic [63:0] Fetch_PC;
    logic        Halted;
    logic        Trap;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Fetch_Count;
    logic [31:0] Flush_Count;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC (64'h0),
        .PROG_END (PROG_END),
        .DEPTH    (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .Inst_Address      (Inst_Address),
        .Instruction       (Instruction),
        .Branch_Taken      (Branch_Taken),
        .Branch_Target     (Branch_Target),
        .Fetch_Valid       (Fetch_Valid),
        .Fetch_Ready       (Fetch_Ready),
        .Fetch_Instruction (Fetch_Instruction),
        .Fetch_PC          (Fetch_PC),
        .Halted            (Halted),
        .Trap              (Trap)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Fetch_Count       (Fetch_Count),
        .Flush_Count       (Flush_Count)
`endif
    );

    // Instruction memory: fixed word at address 0, hashed address elsewhere.
    function automatic logic [31:0] inst_of(input logic [63:0] a);
        logic [31:0] h;
        h = a[31:0] * 32'h9E37_79B1 + 32'h0000_0013;
        return (a == 64'h0) ? 32'h0040_0093 : h;
    endfunction

    assign Instruction = inst_of(Inst_Address);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_pc   = 64'h0;
    bit          m_trap = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] m_fc  = 32'd0;
    logic [31:0] m_flc = 32'd0;
`endif
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: fetch continues while untrapped and PC is below the program end.
    task automatic model_step(input bit rst_n, input bit bt, input logic [63:0] tgt, input bit rdy);
        bit do_pop;
        bit do_push;
        if (!rst_n) begin
            q.delete();
            m_pc   = 64'h0;
            m_trap = 1'b0;
`ifdef FETCH_PERF_CNT_EN
            m_fc  = 32'd0;
            m_flc = 32'd0;
`endif
        end else if (m_trap) begin
            m_trap = 1'b1;
        end else if (bt) begin
`ifdef FETCH_PERF_CNT_EN
            m_flc = m_flc + 32'(q.size());
`endif
            q.delete();
            if (tgt[1:0] != 2'b00) m_trap = 1'b1;
            else m_pc = tgt;
        end else begin
            do_pop  = (q.size() > 0) && rdy;
            do_push = (m_pc < PROG_END) && ((q.size() < DEPTH) || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back('{pc: m_pc, inst: inst_of(m_pc)});
                m_pc = m_pc + 64'd4;
`ifdef FETCH_PERF_CNT_EN
                m_fc = m_fc + 32'd1;
`endif
            end
        end
    endtask

    task automatic check_model();
        bit mv;
        mv = (q.size() != 0);
        chk("model_valid", 64'(Fetch_Valid), 64'(mv));
        chk("model_fetch_pc", Fetch_PC, mv ? q[0].pc : 64'h0);
        chk("model_fetch_inst", 64'(Fetch_Instruction), mv ? 64'(q[0].inst) : 64'h0);
        chk("model_inst_addr", Inst_Address, m_pc);
        chk("model_halted", 64'(Halted), 64'((m_pc >= PROG_END) && !mv));
        chk("model_trap", 64'(Trap), 64'(m_trap));
`ifdef FETCH_PERF_CNT_EN
        chk("model_fetch_count", 64'(Fetch_Count), 64'(m_fc));
        chk("model_flush_count", 64'(Flush_Count), 64'(m_flc));
`endif
    endtask

    task automatic step(input bit rst_n, input bit bt, input logic [63:0] tgt, input bit rdy);
        reset         = rst_n;
        Branch_Taken  = bt;
        Branch_Target = tgt;
        Fetch_Ready   = rdy;
        @(posedge clk);
        model_step(rst_n, bt, tgt, rdy);
        #1;
        check_model();
    endtask

    typedef struct {
        bit          rst_n;
        bit          bt;
        logic [63:0] tgt;
        bit          rdy;
        bit          e_vld;
        logic [63:0] e_pc;
        logic [63:0] e_addr;
        bit          e_halt;
        bit          e_trap;
    } vec_t;

    vec_t tbl[24];

    initial begin
        logic [63:0] last_pc;
        reset         = 1'b0;
        Branch_Taken  = 1'b0;
        Branch_Target = 64'h0;
        Fetch_Ready   = 1'b0;

        //          rst   bt    tgt        rdy  | vld   pc         addr        halt  trap
        tbl[0]  = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h0,   64'h4,   1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h4,   64'h8,   1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h8,   64'hC,   1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   64'h4,   1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   64'h8,   1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   64'h8,   1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   64'h8,   1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   64'h8,   1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h4,   64'hC,   1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h8,   64'h10,  1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 64'h3C,  1'b1, 1'b0, 64'h0,   64'h3C,  1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h3C,  64'h40,  1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h40,  64'h44,  1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 64'h42,  1'b1, 1'b0, 64'h0,   64'h44,  1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 64'h10,  1'b1, 1'b0, 64'h0,   64'h44,  1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   64'h44,  1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h0,   64'h4,   1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 64'h100, 1'b1, 1'b0, 64'h0,   64'h100, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   64'h100, 1'b1, 1'b0};
        tbl[22] = '{1'b1, 1'b1, 64'h2C,  1'b1, 1'b0, 64'h0,   64'h2C,  1'b0, 1'b0};
        tbl[23] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h2C,  64'h30,  1'b0, 1'b0};

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].rst_n, tbl[i].bt, tbl[i].tgt, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 64'(Fetch_Valid), 64'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_fetch_pc", i), Fetch_PC, tbl[i].e_pc);
            chk($sformatf("tbl%0d_fetch_inst", i), 64'(Fetch_Instruction),
                tbl[i].e_vld ? 64'(inst_of(tbl[i].e_pc)) : 64'h0);
            chk($sformatf("tbl%0d_inst_addr", i), Inst_Address, tbl[i].e_addr);
            chk($sformatf("tbl%0d_halted", i), 64'(Halted), 64'(tbl[i].e_halt));
            chk($sformatf("tbl%0d_trap", i), 64'(Trap), 64'(tbl[i].e_trap));
            if (i == 1) chk("first_inst_word", 64'(Fetch_Instruction), 64'h0040_0093);
`ifdef FETCH_PERF_CNT_EN
            if (i == 12) chk("flush_count_after_full_flush", 64'(Flush_Count), 64'd2);
`endif
        end

        // Free-run to the program end, then resume via a redirect.
        step(1'b0, 1'b0, 64'h0, 1'b1);
        last_pc = 64'hDEAD;
        for (int i = 0; i < 100 && !Halted; i++) begin
            step(1'b1, 1'b0, 64'h0, 1'b1);
            if (Fetch_Valid) last_pc = Fetch_PC;
        end
        chk("end_halted", 64'(Halted), 64'h1);
        chk("end_last_pc", last_pc, 64'h90);
        chk("end_valid", 64'(Fetch_Valid), 64'h0);
        chk("end_inst_addr", Inst_Address, 64'h94);
        step(1'b1, 1'b1, 64'h2C, 1'b1);
        step(1'b1, 1'b0, 64'h0, 1'b1);
        chk("resume_valid", 64'(Fetch_Valid), 64'h1);
        chk("resume_pc", Fetch_PC, 64'h2C);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bit          r;
            bit          b;
            bit          rd;
            logic [63:0] t;
            r  = ($urandom_range(0, 63) != 0);
            b  = ($urandom_range(0, 11) == 0);
            rd = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       t = {32'd0, $urandom} | 64'h1;
                1:       t = 64'hFFFF_FFFF_FFFF_FFF8;
                default: t = 64'($urandom_range(0, 44)) << 2;
            endcase
            step(r, b, t, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
